// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU select codes, FSM encoding and instruction field positions
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_SW   = 4'h4;
    localparam logic [3:0] OP_BZ   = 4'h5;
    localparam logic [3:0] OP_BP   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Codes 0..7 are reachable directly from the ALU func field; PASSB sits above them.
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_AND   = 4'h2;
    localparam logic [3:0] ALU_OR    = 4'h3;
    localparam logic [3:0] ALU_XOR   = 4'h4;
    localparam logic [3:0] ALU_PASSB = 4'h8;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int RT_HI  = 5;
    localparam int RT_LO  = 3;
    localparam int FN_HI  = 2;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    function automatic logic [15:0] sext_imm6(input logic [5:0] imm6);
        return {{10{imm6[5]}}, imm6};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational decode of IR and FSM state into datapath controls
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [2:0]  i_state,
    input  logic [15:0] i_ir,
    output logic        o_rf_write,
    output logic [2:0]  o_rs_addr,
    output logic [2:0]  o_rt_addr,
    output logic [2:0]  o_rd_addr,
    output logic [15:0] o_imm_data,
    output logic [3:0]  o_alu_sel,
    output logic        o_imm_sel,
    output logic        o_mem_write,
    output logic        o_mem_sel,
    output logic        o_halted
);

    state_t     w_state;
    logic [3:0] w_op;
    logic       w_active;

    assign w_state  = state_t'(i_state);
    assign w_op     = i_ir[OP_HI:OP_LO];
    // WB only ever follows an LW, but gate on it anyway so no other opcode can write twice.
    assign w_active = (w_state == S_EXEC) || (w_state == S_WB && w_op == OP_LW);

    always_comb begin
        o_rf_write  = 1'b0;
        o_rs_addr   = 3'd0;
        o_rt_addr   = 3'd0;
        o_rd_addr   = 3'd0;
        o_imm_data  = 16'd0;
        o_alu_sel   = ALU_ADD;
        o_imm_sel   = 1'b0;
        o_mem_write = 1'b0;
        o_mem_sel   = 1'b0;
        o_halted    = (w_state == S_HALT);
        if (w_active) begin
            case (w_op)
                OP_ALU: begin
                    o_rd_addr  = i_ir[RD_HI:RD_LO];
                    o_rs_addr  = i_ir[RS_HI:RS_LO];
                    o_rt_addr  = i_ir[RT_HI:RT_LO];
                    o_alu_sel  = {1'b0, i_ir[FN_HI:FN_LO]};
                    o_rf_write = 1'b1;
                end
                OP_ADDI: begin
                    o_rd_addr  = i_ir[RD_HI:RD_LO];
                    o_rs_addr  = i_ir[RS_HI:RS_LO];
                    o_imm_data = sext_imm6(i_ir[IMM_HI:IMM_LO]);
                    o_imm_sel  = 1'b1;
                    o_rf_write = 1'b1;
                end
                OP_LW: begin
                    o_rd_addr  = i_ir[RD_HI:RD_LO];
                    o_rs_addr  = i_ir[RS_HI:RS_LO];
                    o_imm_data = sext_imm6(i_ir[IMM_HI:IMM_LO]);
                    o_imm_sel  = 1'b1;
                    o_mem_sel  = (w_state == S_WB);
                    o_rf_write = (w_state == S_WB);
                end
                OP_SW: begin
                    o_rs_addr   = i_ir[RS_HI:RS_LO];
                    o_imm_data  = sext_imm6(i_ir[IMM_HI:IMM_LO]);
                    o_alu_sel   = ALU_PASSB;
                    o_imm_sel   = 1'b1;
                    o_mem_write = 1'b1;
                end
                OP_BZ, OP_BP: begin
                    // R[rs] + 0 puts the register straight onto the flags.
                    o_rs_addr = i_ir[RS_HI:RS_LO];
                    o_imm_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle sequencer: FSM, program counter and instruction register
module control_unit
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
)
(
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            zero_flag,
    input  logic            pos_flag,
    output logic            rf_write,
    output logic [2:0]      rs_addr,
    output logic [2:0]      rt_addr,
    output logic [2:0]      rd_addr,
    output logic [15:0]     imm_data,
    output logic [3:0]      alu_sel,
    output logic            imm_sel,
    output logic            mem_write,
    output logic            mem_sel,
    output logic            halted
);

    state_t          r_state;
    state_t          w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_br_tgt;
    logic [15:0]     r_ir;
    logic [3:0]      w_op;
    logic [5:0]      w_imm6;

    assign w_op      = r_ir[OP_HI:OP_LO];
    assign w_imm6    = r_ir[IMM_HI:IMM_LO];
    assign w_pc_inc  = r_pc + PC_W'(1);
    assign w_br_tgt  = w_pc_inc + {{(PC_W-6){w_imm6[5]}}, w_imm6};
    assign imem_addr = r_pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                if (w_op == OP_LW)        w_next_state = S_WB;
                else if (w_op == OP_HALT) w_next_state = S_HALT;
                else                      w_next_state = S_FETCH;
            end
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_next = r_pc;
        if (r_state == S_EXEC) begin
            case (w_op)
                OP_LW, OP_HALT: w_pc_next = r_pc;
                OP_BZ:          w_pc_next = zero_flag ? w_br_tgt : w_pc_inc;
                OP_BP:          w_pc_next = pos_flag  ? w_br_tgt : w_pc_inc;
                OP_JMP:         w_pc_next = r_ir[PC_W-1:0];
                default:        w_pc_next = w_pc_inc;
            endcase
        end else if (r_state == S_WB) begin
            w_pc_next = w_pc_inc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
            r_ir <= 16'd0;
        end else begin
            r_pc <= w_pc_next;
            if (r_state == S_DECODE) begin
                r_ir <= imem_data;
            end
        end
    end

    instr_decoder u_decoder (
        .i_state     (r_state),
        .i_ir        (r_ir),
        .o_rf_write  (rf_write),
        .o_rs_addr   (rs_addr),
        .o_rt_addr   (rt_addr),
        .o_rd_addr   (rd_addr),
        .o_imm_data  (imm_data),
        .o_alu_sel   (alu_sel),
        .o_imm_sel   (imm_sel),
        .o_mem_write (mem_write),
        .o_mem_sel   (mem_sel),
        .o_halted    (halted)
    );

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed and randomized checks of control_unit against an instruction-level model
module tb_control_unit;
    import cpu_pkg::ALU_ADD;
    import cpu_pkg::ALU_PASSB;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'd0;
    logic        zero_flag = 1'b0;
    logic        pos_flag  = 1'b0;
    logic        rf_write, imm_sel, mem_write, mem_sel, halted;
    logic [2:0]  rs_addr, rt_addr, rd_addr;
    logic [15:0] imm_data;
    logic [3:0]  alu_sel;

    logic [15:0] rom [256];
    int          exp_pc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    control_unit #(.PC_W(8)) dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .zero_flag(zero_flag), .pos_flag(pos_flag), .rf_write(rf_write),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm_data(imm_data),
        .alu_sel(alu_sel), .imm_sel(imm_sel), .mem_write(mem_write), .mem_sel(mem_sel),
        .halted(halted)
    );

    always #5 clock = ~clock;
    always @(posedge clock) imem_data <= rom[imem_addr];

    function automatic logic [33:0] outs();
        return {rf_write, mem_write, mem_sel, imm_sel, halted, alu_sel, rd_addr, rs_addr, rt_addr, imm_data};
    endfunction

    function automatic int sext6(input logic [15:0] w);
        int v;
        v = int'(w[5:0]);
        if (v >= 32) v -= 64;
        return v;
    endfunction

    // Expected controls from the instruction's meaning; wb selects the write-back cycle of LW.
    function automatic logic [33:0] exp_ctl(input logic [15:0] w, input bit wb);
        logic rfw, mw, ms, ims;
        logic [3:0] alu;
        logic [2:0] rd, rs, rt;
        logic [15:0] imm;
        int sx;
        rfw = 0; mw = 0; ms = 0; ims = 0; alu = ALU_ADD; rd = 0; rs = 0; rt = 0; imm = 0;
        sx = sext6(w);
        case (w[15:12])
            4'h1: begin rfw = 1; rd = w[11:9]; rs = w[8:6]; rt = w[5:3]; alu = {1'b0, w[2:0]}; end
            4'h2: begin rfw = 1; rd = w[11:9]; rs = w[8:6]; imm = 16'(sx); ims = 1; end
            4'h3: begin rfw = wb; ms = wb; rd = w[11:9]; rs = w[8:6]; imm = 16'(sx); ims = 1; end
            4'h4: begin mw = 1; rs = w[8:6]; imm = 16'(sx); ims = 1; alu = ALU_PASSB; end
            4'h5, 4'h6: begin rs = w[8:6]; ims = 1; end
            default: ;
        endcase
        return {rfw, mw, ms, ims, 1'b0, alu, rd, rs, rt, imm};
    endfunction

    function automatic int next_pc(input int pc, input logic [15:0] w, input bit zf, input bit pf);
        bit taken;
        taken = (w[15:12] == 4'h5 && zf) || (w[15:12] == 4'h6 && pf);
        if (w[15:12] == 4'h7) return int'(w[7:0]);
        if (taken) return (pc + 1 + sext6(w) + 256) % 256;
        return (pc + 1) % 256;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Runs one non-HALT instruction from its FETCH cycle to the next FETCH cycle.
    task automatic run_instr(input bit zf, input bit pf);
        logic [15:0] w;
        w = rom[exp_pc];
        chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
        chk("fetch_ctl", 64'(outs()), 64'd0);
        step();
        chk("decode_ctl", 64'(outs()), 64'd0);
        zero_flag = zf;
        pos_flag  = pf;
        step();
        chk("exec_ctl", 64'(outs()), 64'(exp_ctl(w, 1'b0)));
        step();
        if (w[15:12] == 4'h3) begin
            chk("wb_ctl", 64'(outs()), 64'(exp_ctl(w, 1'b1)));
            step();
        end
        exp_pc = next_pc(exp_pc, w, zf, pf);
        chk("next_pc", 64'(imem_addr), 64'(exp_pc));
    endtask

    initial begin
        logic [15:0] rnd;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h2241; rom[1] = 16'h3283; rom[2] = 16'h1A5B; rom[3] = 16'h40A5;
        rom[4] = 16'h9123; rom[5] = 16'h507E; rom[6] = 16'h607E; rom[7] = 16'h70FF;
        rom[8] = 16'h2241; rom[255] = 16'h0000;

        repeat (2) @(negedge clock);
        chk("reset_addr", 64'(imem_addr), 64'd0);
        chk("reset_ctl", 64'(outs()), 64'd0);
        reset = 1'b1;

        run_instr(0, 0);    // ADDI at 0
        run_instr(0, 0);    // LW
        run_instr(0, 0);    // ALU
        run_instr(0, 0);    // SW
        run_instr(0, 0);    // undefined 0x9 at 4
        run_instr(1, 0);    // BZ taken 5 -> 4
        run_instr(0, 0);    // 4 -> 5
        run_instr(0, 1);    // BZ not taken 5 -> 6
        run_instr(0, 1);    // BP taken 6 -> 5
        run_instr(0, 0);    // 5 -> 6
        run_instr(1, 0);    // BP not taken 6 -> 7
        run_instr(0, 0);    // JMP 0xFF
        run_instr(0, 0);    // NOP at 0xFF wraps to 0
        rom[0] = 16'h7008;
        run_instr(0, 0);    // JMP 0x08

        // Abort an ADDI mid-EXEC with an asynchronous reset.
        step();
        step();
        chk("exec_rf_write", 64'(rf_write), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_rf_write", 64'(rf_write), 64'd0);
        chk("abort_pc", 64'(imem_addr), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        rom[0] = 16'h2241;
        exp_pc = 0;
        run_instr(0, 0);

        // Random program; HALT excluded so the model never stops early.
        for (int i = 0; i < 256; i++) begin
            rnd = 16'($urandom());
            rnd[15:12] = 4'($urandom_range(0, 14));
            rom[i] = rnd;
        end
        for (int n = 0; n < 200; n++) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        rom[exp_pc] = 16'hF000;
        chk("halt_fetch", 64'(imem_addr), 64'(exp_pc));
        step();
        step();
        chk("halt_exec_ctl", 64'(outs()), 64'd0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("halt_ctl", 64'(outs()), 64'(34'd1 << 29));
            chk("halt_pc", 64'(imem_addr), 64'(exp_pc));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle instruction sequencer that sits directly upstream of the datapath. It fetches 16-bit instructions from a synchronous instruction ROM, decodes them, and drives every datapath control input: register addresses, immediate, ALU select, mux selects, and write enables. It consumes the datapath's `zero_flag` and `pos_flag` to resolve conditional branches. It owns the program counter and the processor run/halt state.

## Interface
Parameters:
- `PC_W`, default 8: program counter and instruction-address width.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `imem_addr` output PC_W: instruction address, equal to the PC.
- `imem_data` input 16: instruction word, valid one cycle after `imem_addr` (synchronous ROM).
- `zero_flag` input 1: datapath ALU-result-zero flag.
- `pos_flag` input 1: datapath ALU-result-non-negative flag.
- `rf_write` output 1: register-file write enable.
- `rs_addr`, `rt_addr`, `rd_addr` output 3 each: register addresses.
- `imm_data` output 16: sign-extended immediate.
- `alu_sel` output 4: ALU operation.
- `imm_sel` output 1: 1 selects `imm_data` as ALU operand B.
- `mem_write` output 1: data-memory write enable.
- `mem_sel` output 1: 1 selects memory read data for the register-file write.
- `halted` output 1: high while in HALT.

## Operation
Instruction fields:
- `op` = [15:12]
- `rd` = [11:9]
- `rs` = [8:6]
- `rt` = [5:3]
- `func` = [2:0]
- `imm6` = [5:0], sign-extended to 16 bits
- `tgt` = [PC_W-1:0]

Opcodes (package constants):
- `NOP` 0x0
- `ALU` 0x1: `R[rd] <= R[rs] func R[rt]`; `alu_sel = {1'b0, func}`.
- `ADDI` 0x2: `R[rd] <= R[rs] + imm6`.
- `LW` 0x3: `R[rd] <= M[R[rs] + imm6]`.
- `SW` 0x4: `M[imm6] <= R[rs]`; uses `ALU_PASSB`, `imm_sel = 1`.
- `BZ` 0x5: if `R[rs] == 0`, `PC <= PC + 1 + imm6`.
- `BP` 0x6: if `R[rs] >= 0`, `PC <= PC + 1 + imm6`.
- `JMP` 0x7: `PC <= tgt`.
- `HALT` 0xF.
- Any other opcode executes as NOP.

Branch evaluation drives `alu_sel = ALU_ADD`, `imm_sel = 1`, `imm_data = 0`, so that `alu_out = R[rs]`. The flags are sampled at the end of EXEC.

FSM states:
- `FETCH`: present PC on `imem_addr`; go to DECODE.
- `DECODE`: latch `imem_data` into IR; go to EXEC.
- `EXEC`: drive the controls decoded from IR.
  - `LW`: go to WB.
  - `HALT`: go to HALT.
  - All others: update PC and go to FETCH.
- `WB` (LW only): hold the EXEC address controls, assert `mem_sel = 1` and `rf_write = 1`, increment PC, go to FETCH.
- `HALT`: terminal. All enables are 0 and `halted = 1`. Only `reset` leaves this state.

Output and arithmetic rules:
- Control outputs decode combinationally from registered state and IR.
- In FETCH, DECODE and HALT, every enable and select is 0 and all address and data outputs are 0.
- PC arithmetic is modulo 2^PC_W. The PC wraps from 2^PC_W−1 to 0, and branch targets wrap the same way.
- `imm_data` is 16-bit two's-complement sign extension of `imm6`.

## Timing
- Reset (asynchronous, active-low) forces: PC = 0, IR = 0, state = FETCH, all outputs 0, `halted = 0`.
- When reset deasserts, the first FETCH begins on the next rising edge.
- Latency:
  - 3 cycles per instruction (FETCH, DECODE, EXEC).
  - 4 cycles for LW.
  - HALT takes 3 cycles to enter.
- `rf_write` and `mem_write` are asserted for exactly one cycle per instruction. They are never asserted in the same cycle.
- In WB the address outputs equal their EXEC values. This makes a combinational or a one-cycle-synchronous memory read valid.
- Reset asserted mid-instruction aborts it. A write enable that is asserted drops immediately (asynchronously).

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants
  - ALU select codes (`ALU_ADD`, `ALU_SUB`, `ALU_PASSB`, ...), shared with the ALU
  - FSM state encoding
  - instruction field positions
- Sub-module `instr_decoder`: combinational IR + state → control outputs.
- The top level holds the FSM, PC and IR.

## Test plan
- Reset: hold `reset = 0` mid-EXEC of an ADDI → `rf_write` falls immediately, PC = 0. After release, `imem_addr = 0` and the first EXEC occurs at cycle 3.
- ADDI: word 0x2241 (`rd = 1`, `rs = 1`, `imm6 = 1`) → in EXEC: `rd_addr = 1`, `rs_addr = 1`, `imm_data = 0x0001`, `imm_sel = 1`, `alu_sel = ALU_ADD`, `rf_write = 1` for one cycle. PC goes 0→1.
- LW: word 0x3283 → EXEC: `imm_data = 0x0003`, `rf_write = 0`. Next cycle WB: `mem_sel = 1`, `rf_write = 1`, `rd_addr = 1`. Next FETCH at cycle 4.
- Branch: BZ with `imm6 = 0x3E` (−2) at PC = 5. With `zero_flag = 1`, PC becomes 4; with `zero_flag = 0`, PC becomes 6. BP with `pos_flag = 1` behaves the same way.
- Wrap: `PC_W = 8`, NOP at PC 0xFF → PC becomes 0x00. JMP 0x7012 → PC becomes 0x12.
- HALT: word 0xF000 → `halted = 1` and the PC is frozen for 20 cycles with no enables asserted. An undefined opcode 0x9 advances the PC like NOP.
